quant_histogram_rx: RTL

//   Receiving end of the quantizer pixel stream. Accepts one 6-bit quantized colour code per

---
 rtl/quant_pkg.sv | 18 +
 rtl/quant_histogram_rx_hist_bank.sv | 29 ++
 rtl/quant_histogram_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared definitions for the quantizer -> histogram -> classifier pixel path.
package quant_pkg;

    localparam int CODE_W     = 6;
    localparam int NUM_BINS   = 1 << CODE_W;
    localparam int NUM_PIXELS = 4096;
    localparam int ADDR_W     = 12;
    localparam int CNT_W      = 13;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/quant_histogram_rx_hist_bank.sv
// Histogram storage: one counter per colour bin, a clear-write port, an
// increment port that completes its read-modify-write in a single cycle,
// and an asynchronous read port for the drain side.
module hist_bank
    import quant_pkg::*;
(
    input  logic              clk,
    input  logic              clr_we,
    input  logic [CODE_W-1:0] clr_addr,
    input  logic              inc,
    input  logic [CODE_W-1:0] inc_addr,
    input  logic [CODE_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_count
);

    logic [CNT_W-1:0] bin_mem [NUM_BINS];

    // Clear has priority; otherwise bump the addressed bin by one.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            bin_mem[clr_addr] <= '0;
        end else if (inc) begin
            bin_mem[inc_addr] <= bin_mem[inc_addr] + CNT_W'(1);
        end
    end

    assign rd_count = bin_mem[rd_addr];

endmodule

// File: rtl/quant_histogram_rx.sv
// Receives one quantized colour code per handshake for a full image, builds a
// colour histogram, then streams the bins out in index order.
module quant_histogram_rx
    import quant_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              in_ready,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [CODE_W-1:0] bin_idx,
    output logic [CNT_W-1:0]  bin_count,
    output logic              busy,
    output logic              done,
    output logic              err_seq
);

    state_t            state_reg, state_next;
    logic [CODE_W-1:0] clr_idx_reg;
    logic [ADDR_W-1:0] pix_cnt_reg;
    logic [CODE_W-1:0] bin_idx_reg;
    logic              err_seq_reg;

    logic start_acc;
    logic pix_xfer;
    logic bin_xfer;
    logic clr_last;
    logic pix_last;
    logic bin_last;

    // Start only counts when no image is in flight.
    assign start_acc = start && (state_reg == IDLE || state_reg == DONE);
    assign pix_xfer  = in_valid && (state_reg == ACCUM);
    assign bin_xfer  = bin_ready && (state_reg == DRAIN);
    assign clr_last  = (clr_idx_reg == CODE_W'(NUM_BINS - 1));
    assign pix_last  = (pix_cnt_reg == ADDR_W'(NUM_PIXELS - 1));
    assign bin_last  = (bin_idx_reg == CODE_W'(NUM_BINS - 1));

    // State register; reset aborts any image in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: clear all bins, accumulate one image, drain all bins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)              state_next = CLEAR;
            CLEAR:   if (clr_last)           state_next = ACCUM;
            ACCUM:   if (pix_xfer && pix_last) state_next = DRAIN;
            DRAIN:   if (bin_xfer && bin_last) state_next = DONE;
            DONE:    if (start)              state_next = CLEAR;
            default:                         state_next = IDLE;
        endcase
    end

    // Clear pointer, pixel counter, drain index and sticky sequence error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx_reg <= '0;
            pix_cnt_reg <= '0;
            bin_idx_reg <= '0;
            err_seq_reg <= 1'b0;
        end else begin
            if (start_acc) begin
                clr_idx_reg <= '0;
                pix_cnt_reg <= '0;
                err_seq_reg <= 1'b0;
            end
            if (state_reg == CLEAR) begin
                clr_idx_reg <= clr_idx_reg + CODE_W'(1);
            end
            if (pix_xfer) begin
                // Wraps to zero on the last pixel, ready for the next image.
                pix_cnt_reg <= pix_cnt_reg + ADDR_W'(1);
                if (in_addr != pix_cnt_reg) begin
                    err_seq_reg <= 1'b1;
                end
            end
            if (bin_xfer) begin
                // Wraps to zero after the last bin.
                bin_idx_reg <= bin_idx_reg + CODE_W'(1);
            end
        end
    end

    hist_bank u_hist_bank (
        .clk      (clk),
        .clr_we   (state_reg == CLEAR),
        .clr_addr (clr_idx_reg),
        .inc      (pix_xfer),
        .inc_addr (in_code),
        .rd_addr  (bin_idx_reg),
        .rd_count (bin_count)
    );

    assign in_ready  = (state_reg == ACCUM);
    assign bin_valid = (state_reg == DRAIN);
    assign busy      = (state_reg == CLEAR) || (state_reg == ACCUM) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign bin_idx   = bin_idx_reg;
    assign err_seq   = err_seq_reg;

endmodule
